// File: rtl/keypad_code_if.sv
// keypad_code_if: keypad scanner input and lock/indicator output bundle for keypad_code_ctrl.
interface keypad_code_if #(parameter int CODE_LEN = 4);
    logic [4:0]            key_value;
    logic                  key_ready;
    logic                  unlock;
    logic                  locked;
    logic                  fail_pulse;
    logic                  prog_mode;
    logic [3:0]            digit_count;
    logic [4*CODE_LEN-1:0] entry_buf;

    modport master(output key_value, key_ready,
                   input  unlock, locked, fail_pulse, prog_mode, digit_count, entry_buf);
    modport slave(input  key_value, key_ready,
                  output unlock, locked, fail_pulse, prog_mode, digit_count, entry_buf);
endinterface

// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl: debounced key events driving code entry, verify, lockout and code programming.
module keypad_code_ctrl #(
    parameter int                    CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    SETTLE_CYC   = 4,
    parameter int                    UNLOCK_CYC   = 25000000,
    parameter int                    LOCK_CYC     = 250000000
) (
    input logic          clk,
    input logic          rst,
    keypad_code_if.slave bus
);
    localparam int W  = 4*CODE_LEN;
    localparam int TW = $clog2(UNLOCK_CYC > LOCK_CYC ? UNLOCK_CYC : LOCK_CYC) + 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, PROGRAM, LOCKOUT} state_t;

    logic [1:0]    rdy_s;
    logic          rdy_q, busy, key_evt;
    logic [SW-1:0] settle;
    logic [4:0]    key_code;

    state_t        state, n_state;
    logic [W-1:0]  ebuf, n_ebuf, code, n_code, shifted;
    logic [3:0]    cnt, n_cnt;
    logic          ovf, n_ovf, fail_q, n_fail, full, match;
    logic [FW-1:0] fails, n_fails, nf;
    logic [TW-1:0] timer, n_timer;
    logic          is_dig, is_clr, is_ent, is_prg;

    // A press fires once, SETTLE_CYC cycles after the synchronised rise, and only if still held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_s    <= '0;
            rdy_q    <= 1'b0;
            busy     <= 1'b0;
            settle   <= '0;
            key_evt  <= 1'b0;
            key_code <= 5'd16;
        end else begin
            rdy_s   <= {rdy_s[0], bus.key_ready};
            rdy_q   <= rdy_s[1];
            key_evt <= 1'b0;
            if (rdy_s[1] && !rdy_q) begin
                busy   <= 1'b1;
                settle <= SW'(SETTLE_CYC - 1);
            end else if (busy && !rdy_s[1]) begin
                busy <= 1'b0;
            end else if (busy && settle == '0) begin
                busy     <= 1'b0;
                key_evt  <= 1'b1;
                key_code <= bus.key_value;
            end else if (busy) begin
                settle <= settle - 1'b1;
            end
        end
    end

    assign is_dig  = key_evt && key_code < 5'd10;
    assign is_clr  = key_evt && key_code == 5'd10;
    assign is_ent  = key_evt && key_code == 5'd11;
    assign is_prg  = key_evt && key_code == 5'd12;
    assign full    = cnt == 4'(CODE_LEN);
    assign shifted = (ebuf << 4) | W'(key_code[3:0]);
    assign match   = full && !ovf && ebuf == code;
    assign nf      = fails == FW'(MAX_FAIL) ? fails : fails + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ebuf   <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            fails  <= '0;
            code   <= DEFAULT_CODE;
            timer  <= '0;
            fail_q <= 1'b0;
        end else begin
            state  <= n_state;
            ebuf   <= n_ebuf;
            cnt    <= n_cnt;
            ovf    <= n_ovf;
            fails  <= n_fails;
            code   <= n_code;
            timer  <= n_timer;
            fail_q <= n_fail;
        end
    end

    // Timers load N-1 so unlock/locked stay high for exactly N cycles; expiry beats a same-cycle key.
    always_comb begin
        n_state = state;
        n_ebuf  = ebuf;
        n_cnt   = cnt;
        n_ovf   = ovf;
        n_fails = fails;
        n_code  = code;
        n_timer = timer;
        n_fail  = 1'b0;
        case (state)
            IDLE: if (is_dig) begin
                n_ebuf  = W'(key_code[3:0]);
                n_cnt   = 4'd1;
                n_state = ENTRY;
            end
            ENTRY, PROGRAM: begin
                if (is_dig && full) begin
                    n_ovf = 1'b1;
                end else if (is_dig) begin
                    n_ebuf = shifted;
                    n_cnt  = cnt + 4'd1;
                end else if (is_clr) begin
                    {n_ebuf, n_cnt, n_ovf} = '0;
                    n_state = state == PROGRAM ? PROGRAM : IDLE;
                end else if (is_ent && state == ENTRY) begin
                    n_state = CHECK;
                end else if ((is_ent || is_prg) && state == PROGRAM) begin
                    {n_ebuf, n_cnt, n_ovf} = '0;
                    n_state = IDLE;
                    n_code  = is_ent && full && !ovf ? ebuf : code;
                    n_fail  = is_ent && !(full && !ovf);
                end
            end
            CHECK: begin
                {n_ebuf, n_cnt, n_ovf} = '0;
                n_fail  = !match;
                n_fails = match ? '0 : nf;
                n_timer = match ? TW'(UNLOCK_CYC - 1) : TW'(LOCK_CYC - 1);
                n_state = match ? UNLOCKED : (nf == FW'(MAX_FAIL) ? LOCKOUT : IDLE);
            end
            UNLOCKED: begin
                n_timer = timer == '0 ? timer : timer - 1'b1;
                n_state = timer == '0 ? IDLE : (is_prg ? PROGRAM : UNLOCKED);
            end
            LOCKOUT: begin
                n_timer = timer == '0 ? timer : timer - 1'b1;
                n_fails = timer == '0 ? '0 : fails;
                n_state = timer == '0 ? IDLE : LOCKOUT;
            end
            default: n_state = IDLE;
        endcase
    end

    assign bus.unlock      = state == UNLOCKED;
    assign bus.locked      = state == LOCKOUT;
    assign bus.prog_mode   = state == PROGRAM;
    assign bus.fail_pulse  = fail_q;
    assign bus.digit_count = cnt;
    assign bus.entry_buf   = ebuf;
endmodule

// File: tb/tb_keypad_code_ctrl.sv
// tb_keypad_code_ctrl: randomized key sessions checked against a digit-list model of the code lock.
module tb_keypad_code_ctrl;
    typedef int iq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0, errors = 0, m_fails = 0;
    int          u_run = 0, u_last = 0, l_run = 0, l_last = 0, f_tot = 0;
    logic [15:0] m_code = 16'h1234;

    keypad_code_if #(.CODE_LEN(4)) bus();

    keypad_code_ctrl #(.UNLOCK_CYC(1000), .LOCK_CYC(2000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fail_pulse) f_tot++;
        if (bus.unlock) u_run++;
        else if (u_run != 0) begin u_last = u_run; u_run = 0; end
        if (bus.locked) l_run++;
        else if (l_run != 0) begin l_last = l_run; l_run = 0; end
    end

    function automatic logic [15:0] pack(input iq_t q);
        logic [15:0] v = '0;
        for (int i = 0; i < q.size() && i < 4; i++) v = {v[11:0], 4'(q[i])};
        return v;
    endfunction

    function automatic iq_t digits_of(input logic [15:0] c);
        iq_t q;
        for (int i = 3; i >= 0; i--) q.push_back(int'(c[4*i +: 4]));
        return q;
    endfunction

    task automatic press(input int k, input int hold);
        @(negedge clk);
        bus.key_value = 5'(k);
        bus.key_ready = 1'b1;
        repeat (hold) @(negedge clk);
        bus.key_ready = 1'b0;
        bus.key_value = 5'd16;
        repeat (20) @(negedge clk);
    endtask

    task automatic press_all(input iq_t q);
        foreach (q[i]) press(q[i], 100);
    endtask

    task automatic wait_idle(output bit to);
        int t = 0;
        while ((bus.unlock || bus.locked) && t < 5000) begin @(negedge clk); t++; end
        to = bus.unlock || bus.locked;
        @(posedge clk);
    endtask

    task automatic test_reset;
        bus.key_value = 5'd16;
        bus.key_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({bus.unlock, bus.locked, bus.fail_pulse, bus.prog_mode} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.unlock, bus.locked, bus.fail_pulse, bus.prog_mode}); end
        checks++; if (bus.digit_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.digit_count); end
        checks++; if (bus.entry_buf !== 16'h0) begin errors++; $display("FAIL reset_buf: got %h expected 0000", bus.entry_buf); end
        rst = 1'b0;
        m_fails = 0;
        m_code = 16'h1234;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_unlock;
        iq_t q = digits_of(m_code);
        iq_t s;
        int f0;
        bit to;
        foreach (q[i]) begin
            press(q[i], 100);
            s.push_back(q[i]);
            checks++; if (bus.digit_count !== 4'(s.size())) begin errors++; $display("FAIL unlock_count: got %0d expected %0d", bus.digit_count, s.size()); end
            checks++; if (bus.entry_buf !== pack(s)) begin errors++; $display("FAIL unlock_buf: got %h expected %h", bus.entry_buf, pack(s)); end
        end
        f0 = f_tot;
        press(11, 100);
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL unlock_on: got %b expected 1", bus.unlock); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL unlock_timeout: got still high expected low"); end
        checks++; if (u_last != 1000) begin errors++; $display("FAIL unlock_len: got %0d expected 1000", u_last); end
        checks++; if (bus.digit_count !== 4'd0) begin errors++; $display("FAIL unlock_count_clr: got %0d expected 0", bus.digit_count); end
        checks++; if (f_tot != f0) begin errors++; $display("FAIL unlock_nofail: got %0d expected %0d", f_tot, f0); end
        m_fails = 0;
    endtask

    task automatic test_lockout;
        iq_t q;
        int f0, p;
        bit to;
        for (int t = 0; t < 3; t++) begin
            q = digits_of(m_code);
            p = $urandom_range(0, 3);
            q[p] = (q[p] + 1 + $urandom_range(0, 8)) % 10;
            press_all(q);
            f0 = f_tot;
            press(11, 100);
            m_fails++;
            checks++; if (f_tot != f0 + 1) begin errors++; $display("FAIL lock_fail_pulse: got %0d expected %0d", f_tot - f0, 1); end
            checks++; if (bus.locked !== (m_fails >= 3)) begin errors++; $display("FAIL lock_state: got %b expected %b", bus.locked, m_fails >= 3); end
        end
        repeat (3) press($urandom_range(0, 12), 100);
        checks++; if (bus.digit_count !== 4'd0) begin errors++; $display("FAIL lock_keys_ignored: got %0d expected 0", bus.digit_count); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_held: got %b expected 1", bus.locked); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL lock_timeout: got still high expected low"); end
        checks++; if (l_last != 2000) begin errors++; $display("FAIL lock_len: got %0d expected 2000", l_last); end
        m_fails = 0;
        press_all(digits_of(m_code));
        press(11, 100);
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL lock_then_unlock: got %b expected 1", bus.unlock); end
        wait_idle(to);
    endtask

    task automatic test_overflow;
        iq_t q;
        int f0;
        repeat (5) q.push_back($urandom_range(0, 9));
        press_all(q);
        checks++; if (bus.digit_count !== 4'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", bus.digit_count); end
        checks++; if (bus.entry_buf !== pack(q)) begin errors++; $display("FAIL ovf_buf: got %h expected %h", bus.entry_buf, pack(q)); end
        f0 = f_tot;
        press(11, 100);
        m_fails++;
        checks++; if (f_tot != f0 + 1 || bus.unlock !== 1'b0) begin errors++; $display("FAIL ovf_reject: got pulses %0d unlock %b expected 1 and 0", f_tot - f0, bus.unlock); end
        press(1, 100);
        press(2, 100);
        checks++; if (bus.digit_count !== 4'd2) begin errors++; $display("FAIL clr_pre: got %0d expected 2", bus.digit_count); end
        press(10, 100);
        checks++; if (bus.digit_count !== 4'd0 || bus.entry_buf !== 16'h0) begin errors++; $display("FAIL clr_post: got %0d/%h expected 0/0000", bus.digit_count, bus.entry_buf); end
        f0 = f_tot;
        press(11, 100);
        checks++; if (f_tot != f0) begin errors++; $display("FAIL clr_idle_enter: got %0d expected 0", f_tot - f0); end
    endtask

    task automatic test_program;
        iq_t q;
        int f0;
        bit to;
        logic [15:0] nc;
        press_all(digits_of(m_code));
        press(11, 100);
        m_fails = 0;
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL prog_unlock: got %b expected 1", bus.unlock); end
        press(12, 100);
        checks++; if (bus.prog_mode !== 1'b1 || bus.unlock !== 1'b0) begin errors++; $display("FAIL prog_enter: got prog %b unlock %b expected 1 and 0", bus.prog_mode, bus.unlock); end
        do begin
            q.delete();
            repeat (4) q.push_back($urandom_range(0, 9));
            nc = pack(q);
        end while (nc == m_code);
        press_all(q);
        checks++; if (bus.entry_buf !== nc) begin errors++; $display("FAIL prog_buf: got %h expected %h", bus.entry_buf, nc); end
        f0 = f_tot;
        press(11, 100);
        checks++; if (bus.prog_mode !== 1'b0 || f_tot != f0) begin errors++; $display("FAIL prog_store: got prog %b pulses %0d expected 0 and 0", bus.prog_mode, f_tot - f0); end
        press_all(digits_of(m_code));
        f0 = f_tot;
        press(11, 100);
        m_fails++;
        checks++; if (f_tot != f0 + 1 || bus.unlock !== 1'b0) begin errors++; $display("FAIL prog_old_rejected: got pulses %0d unlock %b expected 1 and 0", f_tot - f0, bus.unlock); end
        m_code = nc;
        press_all(digits_of(m_code));
        press(11, 100);
        m_fails = 0;
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL prog_new_accepted: got %b expected 1", bus.unlock); end
        press(12, 100);
        press(4, 100);
        press(5, 100);
        f0 = f_tot;
        press(11, 100);
        checks++; if (f_tot != f0 + 1 || bus.prog_mode !== 1'b0) begin errors++; $display("FAIL prog_short: got pulses %0d prog %b expected 1 and 0", f_tot - f0, bus.prog_mode); end
        press_all(digits_of(m_code));
        press(11, 100);
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL prog_code_kept: got %b expected 1", bus.unlock); end
        wait_idle(to);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_code = 16'h1234;
        m_fails = 0;
        press_all(digits_of(m_code));
        press(11, 100);
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL prog_reset_default: got %b expected 1", bus.unlock); end
        wait_idle(to);
    endtask

    task automatic test_bounce;
        int d = $urandom_range(0, 9);
        press($urandom_range(0, 9), 2);
        checks++; if (bus.digit_count !== 4'd0) begin errors++; $display("FAIL bounce_short: got %0d expected 0", bus.digit_count); end
        press(d, 500);
        checks++; if (bus.digit_count !== 4'd1 || bus.entry_buf !== 16'(d)) begin errors++; $display("FAIL bounce_long: got %0d/%h expected 1/%h", bus.digit_count, bus.entry_buf, 16'(d)); end
        press(16, 100);
        press(13, 100);
        press($urandom_range(14, 15), 100);
        checks++; if (bus.digit_count !== 4'd1 || bus.entry_buf !== 16'(d)) begin errors++; $display("FAIL bounce_nokey: got %0d/%h expected 1/%h", bus.digit_count, bus.entry_buf, 16'(d)); end
        press(10, 100);
        checks++; if (bus.digit_count !== 4'd0) begin errors++; $display("FAIL bounce_clear: got %0d expected 0", bus.digit_count); end
    endtask

    task automatic test_random;
        iq_t q;
        int f0, n;
        bit to, hit;
        for (int s = 0; s < 8; s++) begin
            q.delete();
            if ($urandom_range(0, 1) == 1) q = digits_of(m_code);
            else repeat ($urandom_range(1, 6)) q.push_back($urandom_range(0, 9));
            hit = q.size() == 4 && pack(q) == m_code;
            n = q.size() > 4 ? 4 : q.size();
            press_all(q);
            checks++; if (bus.digit_count !== 4'(n) || bus.entry_buf !== pack(q)) begin errors++; $display("FAIL rand_entry: got %0d/%h expected %0d/%h", bus.digit_count, bus.entry_buf, n, pack(q)); end
            f0 = f_tot;
            press(11, 100);
            if (hit) begin
                m_fails = 0;
                checks++; if (bus.unlock !== 1'b1 || f_tot != f0) begin errors++; $display("FAIL rand_match: got unlock %b pulses %0d expected 1 and 0", bus.unlock, f_tot - f0); end
                wait_idle(to);
                checks++; if (to || u_last != 1000) begin errors++; $display("FAIL rand_unlock_len: got %0d expected 1000", u_last); end
            end else begin
                m_fails++;
                checks++; if (f_tot != f0 + 1) begin errors++; $display("FAIL rand_reject: got %0d expected 1", f_tot - f0); end
                checks++; if (bus.locked !== (m_fails >= 3) || bus.unlock !== 1'b0) begin errors++; $display("FAIL rand_lock: got locked %b unlock %b expected %b and 0", bus.locked, bus.unlock, m_fails >= 3); end
                if (m_fails >= 3) begin
                    wait_idle(to);
                    checks++; if (to || l_last != 2000) begin errors++; $display("FAIL rand_lock_len: got %0d expected 2000", l_last); end
                    m_fails = 0;
                end
            end
        end
    endtask

    task automatic test_async_reset;
        bit to;
        repeat (3) press($urandom_range(0, 9), 100);
        checks++; if (bus.digit_count !== 4'd3) begin errors++; $display("FAIL async_pre: got %0d expected 3", bus.digit_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.digit_count !== 4'd0 || bus.entry_buf !== 16'h0) begin errors++; $display("FAIL async_entry: got %0d/%h expected 0/0000", bus.digit_count, bus.entry_buf); end
        @(negedge clk) rst = 1'b0;
        m_code = 16'h1234;
        m_fails = 0;
        press_all(digits_of(m_code));
        press(11, 100);
        checks++; if (bus.unlock !== 1'b1) begin errors++; $display("FAIL async_unlock_pre: got %b expected 1", bus.unlock); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.unlock, bus.locked, bus.fail_pulse, bus.prog_mode} !== 4'b0 || bus.digit_count !== 4'd0) begin errors++; $display("FAIL async_unlocked: got %b/%0d expected 0000/0", {bus.unlock, bus.locked, bus.fail_pulse, bus.prog_mode}, bus.digit_count); end
        @(negedge clk) rst = 1'b0;
        wait_idle(to);
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_overflow();
        test_program();
        test_bounce();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
